// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a single outstanding instruction-memory
//   request, a one-entry hold buffer for responses that arrive while decode
//   is stalled, and branch/jump redirect handling.
//
// Ports
//   clk            in   1   clock, all state updates on the rising edge
//   rst_n          in   1   synchronous active-low reset
//   stall          in   1   decode cannot accept an instruction this cycle
//   redirect_valid in   1   taken branch/jump resolved this cycle
//   redirect_pc    in  32   branch/jump target
//   imem_req       out  1   instruction-memory request strobe
//   imem_addr      out 32   request address
//   imem_gnt       in   1   request accepted this cycle
//   imem_rvalid    in   1   read data valid
//   imem_rdata     in  32   fetched instruction word
//   inst           out 32   IF/ID instruction
//   inst_valid     out  1   inst is a real instruction (not a bubble)
//   pc_out         out 32   address of inst
//   pc_plus4       out 32   pc_out + 4 (combinational, wraps modulo 2^32)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_drop;
  logic        w_drop_next;
  logic [31:0] r_inst;
  logic [31:0] w_inst_next;
  logic        r_inst_valid;
  logic        w_inst_valid_next;
  logic [31:0] r_pc_out;
  logic [31:0] w_pc_out_next;
  logic [31:0] r_buf_inst;
  logic [31:0] w_buf_inst_next;
  logic [31:0] r_buf_addr;
  logic [31:0] w_buf_addr_next;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        // A granted request is outstanding even if a redirect arrives; the
        // drop flag takes care of the stale response.
        if (imem_gnt) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!redirect_valid && !r_drop && stall) w_state_next = S_HOLD;
          else                                     w_state_next = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect_valid || !stall) w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // Output logic: request only in FETCH, and never while reset is applied
  always_comb begin
    imem_req  = (r_state == S_FETCH) && rst_n;
    imem_addr = r_pc;
  end

  // Datapath next values
  always_comb begin
    w_pc_next         = r_pc;
    w_drop_next       = r_drop;
    w_inst_next       = r_inst;
    w_inst_valid_next = r_inst_valid;
    w_pc_out_next     = r_pc_out;
    w_buf_inst_next   = r_buf_inst;
    w_buf_addr_next   = r_buf_addr;

    if (redirect_valid) begin
      w_pc_next         = {redirect_pc[31:2], 2'b00};
      w_inst_next       = 32'd0;
      w_inst_valid_next = 1'b0;
      w_buf_inst_next   = 32'd0;
      w_buf_addr_next   = 32'd0;
      case (r_state)
        S_FETCH: w_drop_next = imem_gnt;
        S_WAIT:  w_drop_next = !imem_rvalid;
        default: w_drop_next = 1'b0;
      endcase
    end else begin
      // Bubble by default when decode is ready; overridden on delivery.
      if (!stall) begin
        w_inst_next       = 32'd0;
        w_inst_valid_next = 1'b0;
      end
      case (r_state)
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_drop) begin
              w_drop_next = 1'b0;
            end else if (!stall) begin
              w_inst_next       = imem_rdata;
              w_inst_valid_next = 1'b1;
              w_pc_out_next     = r_pc;
              w_pc_next         = r_pc + 32'd4;
            end else begin
              w_buf_inst_next = imem_rdata;
              w_buf_addr_next = r_pc;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_inst_next       = r_buf_inst;
            w_inst_valid_next = 1'b1;
            w_pc_out_next     = r_buf_addr;
            w_pc_next         = r_buf_addr + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
      r_pc_out     <= RESET_PC;
      r_buf_inst   <= 32'd0;
      r_buf_addr   <= 32'd0;
    end else begin
      r_pc         <= w_pc_next;
      r_drop       <= w_drop_next;
      r_inst       <= w_inst_next;
      r_inst_valid <= w_inst_valid_next;
      r_pc_out     <= w_pc_out_next;
      r_buf_inst   <= w_buf_inst_next;
      r_buf_addr   <= w_buf_addr_next;
    end
  end

  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign pc_out     = r_pc_out;
  assign pc_plus4   = r_pc_out + 32'd4;

endmodule
